// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter, debounced
// per-channel duty buttons and boundary-synchronised period, mode and duty updates.
module pwm_multi_ctrl #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEB_DIV     = 4,
  parameter int unsigned STEP        = 1,
  parameter int unsigned PERIOD_INIT = 10,
  parameter int unsigned DUTY_INIT   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CNT_W-1:0]          period_in,
  input  logic                      center_in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*CNT_W-1:0] duty_out,
  output logic                      period_tick
);

  localparam int unsigned     PreW    = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PreW-1:0] PreMax  = PreW'(DEB_DIV - 1);
  localparam logic [CNT_W:0]  StepW   = (CNT_W + 1)'(STEP);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [PreW-1:0]     presc_q, presc_d;
  logic                deb_tick;
  logic [CHANNELS-1:0] inc_s1_q, inc_s2_q, dec_s1_q, dec_s2_q;
  logic [CHANNELS-1:0] inc_press, dec_press;
  logic [CNT_W-1:0]    cnt_q, cnt_d, period_q, period_d;
  logic                center_q, center_d;
  dir_e                dir_q, dir_d;
  logic                boundary, load, at_top;
  logic [CNT_W-1:0]    shadow_q [CHANNELS];
  logic [CNT_W-1:0]    shadow_d [CHANNELS];
  logic [CNT_W-1:0]    active_q [CHANNELS];
  logic [CNT_W-1:0]    active_d [CHANNELS];
  logic [CNT_W:0]      inc_sum  [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                tick_q, tick_d;

  // Debounce: samplers only advance on the prescaler tick.
  assign deb_tick  = (presc_q == PreMax);
  assign presc_d   = deb_tick ? '0 : presc_q + PreW'(1);
  assign inc_press = inc_s1_q & ~inc_s2_q & {CHANNELS{deb_tick}};
  assign dec_press = dec_s1_q & ~dec_s2_q & {CHANNELS{deb_tick}};

  // Counter/direction state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dir_q <= DirUp;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Boundary decode from the current counter state.
  always_comb begin
    boundary = (cnt_q == '0) && (!center_q || (dir_q == DirUp));
    load     = boundary & en;
  end

  always_comb begin
    period_d = period_q;
    center_d = center_q;
    if (load) begin
      period_d = (period_in == '0) ? CntOne : period_in;
      center_d = center_in;
    end
  end

  // Next counter state; period_d/center_d already reflect a load at the boundary.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    at_top = (cnt_q == period_d - CntOne);
    if (en) begin
      if (!center_d) begin
        dir_d = DirUp;
        cnt_d = at_top ? '0 : cnt_q + CntOne;
      end else begin
        unique case (dir_q)
          DirUp: begin
            if (at_top) dir_d = DirDown;
            else        cnt_d = cnt_q + CntOne;
          end
          DirDown: begin
            if (cnt_q == '0) dir_d = DirUp;
            else             cnt_d = cnt_q - CntOne;
          end
          default: dir_d = DirUp;
        endcase
      end
    end
  end

  // Shadow duty tracks presses; active duty only changes at a boundary.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      inc_sum[i]  = {1'b0, shadow_q[i]} + StepW;
      shadow_d[i] = shadow_q[i];
      if (inc_press[i] && !dec_press[i]) begin
        shadow_d[i] = (inc_sum[i] > {1'b0, period_q}) ? period_q : inc_sum[i][CNT_W-1:0];
      end else if (dec_press[i] && !inc_press[i]) begin
        shadow_d[i] = ({1'b0, shadow_q[i]} < StepW) ? '0 : shadow_q[i] - StepW[CNT_W-1:0];
      end
      active_d[i] = active_q[i];
      if (load) begin
        if (shadow_d[i] > period_d) shadow_d[i] = period_d;
        active_d[i] = shadow_d[i];
      end
      pwm_d[i]                     = en & (cnt_q < active_d[i]);
      duty_out[i*CNT_W +: CNT_W]   = active_q[i];
    end
    tick_d = load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      inc_s1_q <= '0;
      inc_s2_q <= '0;
      dec_s1_q <= '0;
      dec_s2_q <= '0;
      period_q <= CNT_W'(PERIOD_INIT);
      center_q <= 1'b0;
      pwm_q    <= '0;
      tick_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= CNT_W'(DUTY_INIT);
        active_q[i] <= CNT_W'(DUTY_INIT);
      end
    end else begin
      presc_q <= presc_d;
      if (deb_tick) begin
        inc_s1_q <= inc;
        inc_s2_q <= inc_s1_q;
        dec_s1_q <= dec;
        dec_s2_q <= dec_s1_q;
      end
      period_q <= period_d;
      center_q <= center_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Scoreboard bench for pwm_multi_ctrl: a phase-based reference model queues the expected
// outputs of every clock and a monitor compares them with the DUT on the falling edge.
module tb_pwm_multi_ctrl;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int DD   = 4;
  localparam int STEP = 1;
  localparam int PI   = 10;
  localparam int DI   = 5;

  logic              clk = 1'b0;
  logic              rst, en, center_in;
  logic [CH-1:0]     inc, dec, pwm_out;
  logic [W-1:0]      period_in;
  logic [CH*W-1:0]   duty_out;
  logic              period_tick;

  pwm_multi_ctrl #(
    .CHANNELS   (CH),
    .CNT_W      (W),
    .DEB_DIV    (DD),
    .STEP       (STEP),
    .PERIOD_INIT(PI),
    .DUTY_INIT  (DI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .inc        (inc),
    .dec        (dec),
    .period_in  (period_in),
    .center_in  (center_in),
    .pwm_out    (pwm_out),
    .duty_out   (duty_out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]   pwm;
    logic            tick;
    logic [CH*W-1:0] duty;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ticks  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: position within the period (phase) plus per-button sample history.
  int m_phase, m_p, m_presc;
  bit m_center;
  int m_shadow [CH];
  int m_active [CH];
  bit m_inc_new[CH], m_inc_old[CH], m_dec_new[CH], m_dec_old[CH];

  always @(posedge clk) begin : model
    exp_t e;
    int   len, cval;
    bit   dtick, bnd, pr_i, pr_d;
    e = '0;
    if (rst) begin
      m_phase  = 0;
      m_p      = PI;
      m_center = 1'b0;
      m_presc  = 0;
      for (int i = 0; i < CH; i++) begin
        m_shadow[i]  = DI;
        m_active[i]  = DI;
        m_inc_new[i] = 1'b0;
        m_inc_old[i] = 1'b0;
        m_dec_new[i] = 1'b0;
        m_dec_old[i] = 1'b0;
      end
    end else begin
      dtick   = (m_presc == DD - 1);
      m_presc = (m_presc + 1) % DD;
      for (int i = 0; i < CH; i++) begin
        pr_i = dtick && m_inc_new[i] && !m_inc_old[i];
        pr_d = dtick && m_dec_new[i] && !m_dec_old[i];
        if (dtick) begin
          m_inc_old[i] = m_inc_new[i];
          m_inc_new[i] = inc[i];
          m_dec_old[i] = m_dec_new[i];
          m_dec_new[i] = dec[i];
        end
        if (pr_i && !pr_d) begin
          m_shadow[i] = (m_shadow[i] + STEP > m_p) ? m_p : m_shadow[i] + STEP;
        end else if (pr_d && !pr_i) begin
          m_shadow[i] = (m_shadow[i] < STEP) ? 0 : m_shadow[i] - STEP;
        end
      end
      if (en) begin
        bnd = (m_phase == 0);
        if (bnd) begin
          m_p      = (period_in == '0) ? 1 : int'(period_in);
          m_center = center_in;
          for (int i = 0; i < CH; i++) begin
            if (m_shadow[i] > m_p) m_shadow[i] = m_p;
            m_active[i] = m_shadow[i];
          end
        end
        len  = m_center ? 2 * m_p : m_p;
        cval = (m_phase < m_p) ? m_phase : 2 * m_p - 1 - m_phase;
        for (int i = 0; i < CH; i++) e.pwm[i] = (cval < m_active[i]);
        e.tick  = bnd;
        m_phase = (m_phase + 1) % len;
      end
    end
    for (int i = 0; i < CH; i++) e.duty[i*W +: W] = W'(m_active[i]);
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("pwm_out", 64'(pwm_out), 64'(e.pwm));
      check("period_tick", 64'(period_tick), 64'(e.tick));
      check("duty_out", 64'(duty_out), 64'(e.duty));
      if (period_tick) n_ticks++;
    end
  end

  task automatic press(input logic [CH-1:0] im, input logic [CH-1:0] dm);
    inc = im;
    dec = dm;
    repeat (3 * DD) @(negedge clk);
    inc = '0;
    dec = '0;
    repeat (3 * DD) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    inc       = '0;
    dec       = '0;
    period_in = W'(10);
    center_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    repeat (30) @(negedge clk);

    press(4'b0001, 4'b0000);
    repeat (20) @(negedge clk);

    repeat (6) press(4'b0010, 4'b0000);
    repeat (20) @(negedge clk);
    repeat (11) press(4'b0000, 4'b0010);
    repeat (20) @(negedge clk);

    press(4'b0100, 4'b0100);
    repeat (20) @(negedge clk);

    period_in = W'(4);
    center_in = 1'b1;
    repeat (40) @(negedge clk);

    period_in = W'(3);
    center_in = 1'b0;
    repeat (30) @(negedge clk);
    period_in = W'(0);
    repeat (20) @(negedge clk);

    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) inc = CH'($urandom);
      if ($urandom_range(0, 15) == 0) dec = CH'($urandom);
      if ($urandom_range(0, 40) == 0) period_in = W'($urandom_range(0, 12));
      if ($urandom_range(0, 60) == 0) center_in = 1'($urandom);
      en = ($urandom_range(0, 19) != 0);
    end

    en        = 1'b1;
    inc       = '0;
    dec       = '0;
    period_in = W'(6);
    center_in = 1'b1;
    repeat (23) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    period_in = W'(10);
    center_in = 1'b0;
    repeat (40) @(negedge clk);

    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    check("ticks_seen", 64'(n_ticks > 0), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
